wide_add_sequencer: RTL and testbench

- Upstream/downstream companion to the pipelined 8-bit Brent-Kung adder.
- Accepts one W-bit add request, splits it into SLICES = W/N byte slices, and issues them LSB-first to the N-bit adder, chaining carry-out to carry-in.
- Collects the slice sums into a W-bit result and returns it with a done pulse.
- Also watches the adder handshake and aborts with an error if a slice result never returns.

---
 rtl/wide_add_sequencer.sv | 139 +++++++++++++
 tb/tb_wide_add_sequencer.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/wide_add_sequencer.sv
// Splits one W-bit add into N-bit slices, issues them LSB-first to an external
// pipelined adder with carry chaining, and reassembles the W-bit sum.
module wide_add_sequencer #(
    parameter int unsigned W       = 32,
    parameter int unsigned N       = 8,
    parameter int unsigned SLICES  = W / N,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         iValid,
    input  logic [W-1:0] iX,
    input  logic [W-1:0] iY,
    input  logic         iCarryIn,
    output logic         oAccept,
    output logic         oAddValid,
    output logic [N-1:0] oAddX,
    output logic [N-1:0] oAddY,
    output logic         oAddCarryIn,
    input  logic         iAddReady,
    input  logic [N-1:0] iAddZ,
    input  logic         iAddCarryOut,
    output logic [W-1:0] oZ,
    output logic         oCarryOut,
    output logic         oDone,
    output logic         oError
);

    localparam int unsigned KW = (SLICES > 1) ? $clog2(SLICES) : 1;
    localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_t;

    state_t         state_q;
    logic [KW-1:0]  k_q;
    logic [CW-1:0]  cnt_q;
    // Operands shift right one slice per issue; the sum shifts in from the top.
    logic [W-1:0]   x_q;
    logic [W-1:0]   y_q;
    logic [W-1:0]   z_q;
    logic [W-1:0]   oz_q;
    logic [N-1:0]   add_x_q;
    logic [N-1:0]   add_y_q;
    logic           add_cin_q;
    logic           add_valid_q;
    logic           accept_q;
    logic           done_q;
    logic           error_q;
    logic           co_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= StIdle;
            k_q         <= '0;
            cnt_q       <= '0;
            x_q         <= '0;
            y_q         <= '0;
            z_q         <= '0;
            oz_q        <= '0;
            add_x_q     <= '0;
            add_y_q     <= '0;
            add_cin_q   <= 1'b0;
            add_valid_q <= 1'b0;
            accept_q    <= 1'b1;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            co_q        <= 1'b0;
        end else begin
            add_valid_q <= 1'b0;
            done_q      <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (iValid) begin
                        x_q         <= iX >> N;
                        y_q         <= iY >> N;
                        add_x_q     <= iX[N-1:0];
                        add_y_q     <= iY[N-1:0];
                        add_cin_q   <= iCarryIn;
                        k_q         <= '0;
                        error_q     <= 1'b0;
                        accept_q    <= 1'b0;
                        add_valid_q <= 1'b1;
                        state_q     <= StIssue;
                    end
                end
                StIssue: begin
                    cnt_q   <= '0;
                    state_q <= StWait;
                end
                StWait: begin
                    if (iAddReady) begin
                        z_q       <= {iAddZ, z_q[W-1:N]};
                        add_cin_q <= iAddCarryOut;
                        if (k_q == KW'(SLICES - 1)) begin
                            oz_q    <= {iAddZ, z_q[W-1:N]};
                            co_q    <= iAddCarryOut;
                            done_q  <= 1'b1;
                            state_q <= StDone;
                        end else begin
                            k_q         <= k_q + 1'b1;
                            add_x_q     <= x_q[N-1:0];
                            add_y_q     <= y_q[N-1:0];
                            x_q         <= x_q >> N;
                            y_q         <= y_q >> N;
                            add_valid_q <= 1'b1;
                            state_q     <= StIssue;
                        end
                    end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                        // Slice result never arrived: abandon, keep last good sum.
                        error_q  <= 1'b1;
                        accept_q <= 1'b1;
                        state_q  <= StIdle;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StDone: begin
                    accept_q <= 1'b1;
                    state_q  <= StIdle;
                end
                default: begin
                    accept_q <= 1'b1;
                    state_q  <= StIdle;
                end
            endcase
        end
    end

    assign oAccept     = accept_q;
    assign oAddValid   = add_valid_q;
    assign oAddX       = add_x_q;
    assign oAddY       = add_y_q;
    assign oAddCarryIn = add_cin_q;
    assign oZ          = oz_q;
    assign oCarryOut   = co_q;
    assign oDone       = done_q;
    assign oError      = error_q;

endmodule

// File: tb/tb_wide_add_sequencer.sv
// Directed bench for wide_add_sequencer with a behavioural 2-stage slice adder.
module tb_wide_add_sequencer;

    localparam int unsigned W = 32;
    localparam int unsigned N = 8;

    logic         clk = 1'b0;
    logic         resetn;
    logic         iValid;
    logic [W-1:0] iX;
    logic [W-1:0] iY;
    logic         iCarryIn;
    logic         oAccept;
    logic         oAddValid;
    logic [N-1:0] oAddX;
    logic [N-1:0] oAddY;
    logic         oAddCarryIn;
    logic         iAddReady;
    logic [N-1:0] iAddZ;
    logic         iAddCarryOut;
    logic [W-1:0] oZ;
    logic         oCarryOut;
    logic         oDone;
    logic         oError;

    int tests = 0;
    int fails = 0;

    wide_add_sequencer #(.W(W), .N(N), .SLICES(W / N), .TIMEOUT(15)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .iValid      (iValid),
        .iX          (iX),
        .iY          (iY),
        .iCarryIn    (iCarryIn),
        .oAccept     (oAccept),
        .oAddValid   (oAddValid),
        .oAddX       (oAddX),
        .oAddY       (oAddY),
        .oAddCarryIn (oAddCarryIn),
        .iAddReady   (iAddReady),
        .iAddZ       (iAddZ),
        .iAddCarryOut(iAddCarryOut),
        .oZ          (oZ),
        .oCarryOut   (oCarryOut),
        .oDone       (oDone),
        .oError      (oError)
    );

    always #5 clk = ~clk;

    // Behavioural adder, L=2; a slice index can be withheld, stray readies injected.
    int         withhold  = -1;
    int         issue_idx = 0;
    logic       stray     = 1'b0;
    logic       s1_v = 1'b0, s2_v = 1'b0;
    logic [N:0] s1_s = '0, s2_s = '0;

    always @(posedge clk) begin
        if (oAccept && iValid) issue_idx <= 0;
        else if (oAddValid) issue_idx <= issue_idx + 1;
        s1_v <= oAddValid && (issue_idx != withhold);
        s1_s <= {1'b0, oAddX} + {1'b0, oAddY} + {{N{1'b0}}, oAddCarryIn};
        s2_v <= s1_v;
        s2_s <= s1_s;
    end

    assign iAddReady    = s2_v | stray;
    assign iAddZ        = s2_s[N-1:0];
    assign iAddCarryOut = s2_s[N];

    typedef struct {
        logic [W-1:0] x;
        logic [W-1:0] y;
        logic         cin;
        logic [W-1:0] exp_z;
        logic         exp_co;
        logic [3:0]   exp_cins;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int         n;
        int         pulses;
        logic [3:0] cins;
        logic       seen_done;
        n = 0; pulses = 0; cins = '0; seen_done = 1'b0;
        @(negedge clk);
        check({tag, " accept ready"}, 64'(oAccept), 64'd1);
        iX = v.x; iY = v.y; iCarryIn = v.cin; iValid = 1'b1;
        @(negedge clk);
        iValid = 1'b0;
        check({tag, " error cleared"}, 64'(oError), 64'd0);
        while (n < 100) begin
            if (oAddValid) begin
                if (pulses < 4) cins[pulses] = oAddCarryIn;
                pulses++;
            end
            if (oDone) begin
                seen_done = 1'b1;
                break;
            end
            @(negedge clk);
            n++;
        end
        check({tag, " done seen"}, 64'(seen_done), 64'd1);
        check({tag, " latency"}, 64'(n), 64'd12);
        check({tag, " sum"}, 64'(oZ), 64'(v.exp_z));
        check({tag, " carry out"}, 64'(oCarryOut), 64'(v.exp_co));
        check({tag, " error"}, 64'(oError), 64'd0);
        check({tag, " issue pulses"}, 64'(pulses), 64'd4);
        check({tag, " slice carry-ins"}, 64'(cins), 64'(v.exp_cins));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   n;
        int   pulses;
        int   done_n;
        int   acc_n;
        int   acc_t[3];
        logic seen;

        vecs[0] = '{32'h0000_0001, 32'h0000_0002, 1'b0, 32'h0000_0003, 1'b0, 4'b0000};
        vecs[1] = '{32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1, 4'b1111};
        vecs[2] = '{32'h8000_00FF, 32'h8000_0001, 1'b0, 32'h0000_0100, 1'b1, 4'b0010};
        vecs[3] = '{32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 32'hACF1_3568, 1'b0, 4'b0110};
        vecs[4] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 4'b1110};

        resetn = 1'b0; iValid = 1'b0; iX = '0; iY = '0; iCarryIn = 1'b0;
        repeat (3) @(negedge clk);
        check("reset oZ", 64'(oZ), 64'd0);
        check("reset oCarryOut", 64'(oCarryOut), 64'd0);
        check("reset oDone", 64'(oDone), 64'd0);
        check("reset oError", 64'(oError), 64'd0);
        check("reset oAddValid", 64'(oAddValid), 64'd0);
        check("reset oAddX", 64'(oAddX), 64'd0);
        check("reset oAddCarryIn", 64'(oAddCarryIn), 64'd0);
        resetn = 1'b1;
        @(negedge clk);
        check("post-reset oAccept", 64'(oAccept), 64'd1);

        for (int i = 0; i < 5; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Timeout: slice 2 never returns.
        withhold = 2;
        @(negedge clk);
        iX = 32'h0101_0101; iY = 32'h0202_0202; iCarryIn = 1'b0; iValid = 1'b1;
        @(negedge clk);
        iValid = 1'b0;
        n = 0; seen = 1'b0;
        while (n < 60 && !oError) begin
            if (oDone) seen = 1'b1;
            @(negedge clk);
            n++;
        end
        check("timeout edges", 64'(n), 64'd22);
        check("timeout error", 64'(oError), 64'd1);
        check("timeout no done", 64'(seen), 64'd0);
        check("timeout accept", 64'(oAccept), 64'd1);
        check("timeout oZ kept", 64'(oZ), 64'(vecs[4].exp_z));
        check("timeout co kept", 64'(oCarryOut), 64'(vecs[4].exp_co));
        withhold = -1;
        run_vec('{32'h0000_0010, 32'h0000_0020, 1'b0, 32'h0000_0030, 1'b0, 4'b0000}, "recover");

        // iValid held high through two operations with stray readies.
        @(negedge clk);
        iX = 32'h0000_00FF; iY = 32'h0000_0001; iCarryIn = 1'b0; iValid = 1'b1;
        done_n = 0; acc_n = 0; acc_t = '{0, 0, 0};
        for (int cyc = 0; cyc < 60 && done_n < 2; cyc++) begin
            stray = oAddValid | oAccept;
            if (oAccept && iValid && acc_n < 3) begin
                acc_t[acc_n] = cyc;
                acc_n++;
            end
            if (oDone) begin
                if (done_n == 0) begin
                    check("hold sum A", 64'(oZ), 64'h100);
                    iX = 32'h7FFF_FFFF; iY = 32'h0000_0001;
                end else begin
                    check("hold sum B", 64'(oZ), 64'h8000_0000);
                    iValid = 1'b0;
                end
                done_n++;
            end
            if (done_n < 2) @(negedge clk);
        end
        stray  = 1'b0;
        iValid = 1'b0;
        check("hold dones", 64'(done_n), 64'd2);
        check("hold accepts", 64'(acc_n), 64'd2);
        check("hold accept spacing", 64'(acc_t[1] - acc_t[0]), 64'd14);

        // Reset during WAIT of slice 1.
        @(negedge clk);
        iX = 32'h0000_1111; iY = 32'h0000_2222; iCarryIn = 1'b0; iValid = 1'b1;
        @(negedge clk);
        iValid = 1'b0;
        n = 0; pulses = 0;
        while (n < 40 && pulses < 2) begin
            if (oAddValid) pulses++;
            if (pulses < 2) begin
                @(negedge clk);
                n++;
            end
        end
        check("reset-test slice1 issued", 64'(pulses), 64'd2);
        @(negedge clk);
        resetn = 1'b0;
        #1;
        check("mid reset oAddValid", 64'(oAddValid), 64'd0);
        check("mid reset oDone", 64'(oDone), 64'd0);
        check("mid reset oZ", 64'(oZ), 64'd0);
        check("mid reset oError", 64'(oError), 64'd0);
        @(negedge clk);
        resetn = 1'b1;
        seen = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (oDone || oError) seen = 1'b1;
        end
        check("no done after reset", 64'(seen), 64'd0);
        run_vec(vecs[3], "after reset");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
